// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Definitions shared by the kitchen-timer blocks: FSM state encodings,
// active-low seven-segment patterns ({g,f,e,d,c,b,a}), and the packed
// four-digit BCD bundle used for the display snapshot.
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_GETMIN = 3'd2,
        ST_GETSEC = 3'd3,
        ST_COUNT  = 3'd4,
        ST_PAUSE  = 3'd5
    } timer_state_e;

    typedef struct packed {
        logic [3:0] min_1;
        logic [3:0] min_0;
        logic [3:0] sec_1;
        logic [3:0] sec_0;
    } digits_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to active-low seven-segment decoder. Codes 10..15 are not
// valid BCD and show a dash so a corrupted digit is visible on the display.
//   bcd_i  in  4  BCD digit
//   seg_o  out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_display_mux.sv
// -----------------------------------------------------------------------------
// seg7_display_mux
// Time-multiplexes the kitchen-timer digits onto a 4-digit common-anode
// seven-segment display with a colon. Each digit slot starts with a guard
// interval (all anodes off) to hide ghosting. The display blinks while paused
// or when the alarm is active; the colon flashes while counting.
//   clock    in   1  system clock
//   reset_n  in   1  asynchronous active-low reset
//   min_1..sec_0 in 4 each  BCD digits, latched once per frame
//   state    in   3  timer FSM state (sampled every cycle)
//   led      in   1  alarm flag (sampled every cycle)
//   an       out  4  anode enables, active-low, an[0]=sec_0 .. an[3]=min_1
//   seg      out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp       out  1  colon, active-low
// -----------------------------------------------------------------------------
module seg7_display_mux
    import timer_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 2000,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] min_1,
    input  logic [3:0] min_0,
    input  logic [3:0] sec_1,
    input  logic [3:0] sec_0,
    input  logic [2:0] state,
    input  logic       led,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    digits_t       snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          rcnt_wrap;
    logic          bcnt_wrap;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;
    logic          blank_blink;
    logic          an_off;

    seg7_decode u_decode (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    always_comb begin
        rcnt_wrap = (rcnt_q == RW'(REFRESH_DIV - 1));
        bcnt_wrap = (bcnt_q == BW'(BLINK_DIV - 1));

        rcnt_d  = rcnt_wrap ? '0 : rcnt_q + 1'b1;
        idx_d   = rcnt_wrap ? idx_q + 2'd1 : idx_q;
        bcnt_d  = bcnt_wrap ? '0 : bcnt_q + 1'b1;
        phase_d = bcnt_wrap ? ~phase_q : phase_q;

        // New digits are only taken at the frame boundary so a frame is never
        // a mix of old and new values.
        snap_d = snap_q;
        if (rcnt_wrap && (idx_q == 2'd3)) begin
            snap_d = '{min_1: min_1, min_0: min_0, sec_1: sec_1, sec_0: sec_0};
        end

        cur_digit = snap_q.sec_0;
        case (idx_q)
            2'd0: cur_digit = snap_q.sec_0;
            2'd1: cur_digit = snap_q.sec_1;
            2'd2: cur_digit = snap_q.min_0;
            2'd3: cur_digit = snap_q.min_1;
            default: cur_digit = snap_q.sec_0;
        endcase

        // States 6/7 fall through as non-pause, non-count: no blink, steady colon.
        blank_blink = (led || (state == ST_PAUSE)) && phase_q;

        an_off = (rcnt_q < RW'(GUARD))
               || blank_blink
               || (LZ_BLANK && (idx_q == 2'd3) && (snap_q.min_1 == 4'd0));

        an_d  = an_off ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = cur_seg;
        dp_d  = ~((idx_q == 2'd2) && !an_off
                  && ((state != ST_COUNT) || !phase_q));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_display_mux.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_mux
// Directed bench for seg7_display_mux with REFRESH_DIV=4, GUARD=1,
// BLINK_DIV=16, LZ_BLANK=1. Counting posedges after reset release as 1, 2, ..
// the outputs seen just after edge n come from m=n-1: rcnt=m%4,
// idx=(m/4)%4, blink phase=(m/16)%2. One frame = 16 cycles, so odd frames are
// the blink-off phase. Frame f uses digits present at edge 16f.
// -----------------------------------------------------------------------------
module tb_seg7_display_mux;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] min_1 = 4'd1;
    logic [3:0] min_0 = 4'd2;
    logic [3:0] sec_1 = 4'd3;
    logic [3:0] sec_0 = 4'd4;
    logic [2:0] state = 3'd0;
    logic       led = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    seg7_display_mux #(
        .REFRESH_DIV (4),
        .GUARD       (1),
        .BLINK_DIV   (16),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .min_1   (min_1),
        .min_0   (min_0),
        .sec_1   (sec_1),
        .sec_0   (sec_0),
        .state   (state),
        .led     (led),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_at(input int n, input string tag,
                             input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        goto(n);
        check(tag, {an, seg, dp}, {e_an, e_seg, e_dp});
    endtask

    task automatic set_digits(input logic [3:0] m1, input logic [3:0] m0,
                              input logic [3:0] s1, input logic [3:0] s0);
        min_1 = m1;
        min_0 = m0;
        sec_1 = s1;
        sec_0 = s0;
    endtask

    initial begin
        // Reset held for 3 cycles with digits 1,2,3,4
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold", {an, seg, dp}, {4'b1111, SOFF, 1'b1});
        @(negedge clock);
        reset_n = 1'b1;

        // Frame 0: zero snapshot from reset, min_1 blanked
        expect_at(1,  "f0_guard_idx0", 4'b1111, S0, 1'b1);
        expect_at(2,  "f0_idx0",       4'b1110, S0, 1'b1);
        expect_at(10, "f0_idx2_colon", 4'b1011, S0, 1'b0);
        expect_at(14, "f0_idx3_lz",    4'b1111, S0, 1'b1);

        // Frame 1: digits 1,2,3,4 latched at edge 16
        expect_at(18, "f1_idx0_4",     4'b1110, S4, 1'b1);
        expect_at(22, "f1_idx1_3",     4'b1101, S3, 1'b1);
        expect_at(26, "f1_idx2_2",     4'b1011, S2, 1'b0);
        expect_at(30, "f1_idx3_1",     4'b0111, S1, 1'b1);
        set_digits(4'd0, 4'd5, 4'd3, 4'd9);

        // Frame 2: guard and scan order with min_1=0
        expect_at(33, "f2_guard0",     4'b1111, S9, 1'b1);
        expect_at(34, "f2_idx0",       4'b1110, S9, 1'b1);
        expect_at(36, "f2_idx0_last",  4'b1110, S9, 1'b1);
        expect_at(37, "f2_guard1",     4'b1111, S3, 1'b1);
        expect_at(38, "f2_idx1",       4'b1101, S3, 1'b1);
        expect_at(41, "f2_guard2",     4'b1111, S5, 1'b1);
        expect_at(42, "f2_idx2",       4'b1011, S5, 1'b0);
        expect_at(46, "f2_idx3_lz",    4'b1111, S0, 1'b1);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);

        // Frame 3: change digits mid-frame, frame must stay on old values
        expect_at(50, "f3_idx0_4",     4'b1110, S4, 1'b1);
        expect_at(54, "f3_idx1_3",     4'b1101, S3, 1'b1);
        sec_0 = 4'd7;
        min_0 = 4'd8;
        expect_at(58, "f3_no_tear_m0", 4'b1011, S2, 1'b0);
        expect_at(62, "f3_idx3_1",     4'b0111, S1, 1'b1);

        // Frame 4: new values appear
        expect_at(66, "f4_new_sec0",   4'b1110, S7, 1'b1);
        expect_at(74, "f4_new_min0",   4'b1011, S8, 1'b0);
        state = 3'd5;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        expect_at(78, "f4_pause_ph0",  4'b0111, S1, 1'b1);

        // Frame 5: pause, blink phase 1 -> all dark, seg still driven
        expect_at(82, "f5_pause_off0", 4'b1111, S4, 1'b1);
        expect_at(90, "f5_pause_off2", 4'b1111, S2, 1'b1);
        expect_at(94, "f5_pause_off3", 4'b1111, S1, 1'b1);

        // Frame 6: pause, phase 0 -> scanning, steady colon
        expect_at(98,  "f6_pause_on0", 4'b1110, S4, 1'b1);
        expect_at(106, "f6_pause_dp",  4'b1011, S2, 1'b0);
        state = 3'd4;
        expect_at(107, "f6_count_dp0", 4'b1011, S2, 1'b0);

        // Frame 7: counting, phase 1 -> no blank, colon off
        expect_at(114, "f7_count_on",  4'b1110, S4, 1'b1);
        expect_at(122, "f7_count_dp1", 4'b1011, S2, 1'b1);

        // Frame 8: counting, phase 0 -> colon lit
        expect_at(138, "f8_count_dp0", 4'b1011, S2, 1'b0);
        state = 3'd0;
        led = 1'b1;
        expect_at(140, "f8_alarm_ph0", 4'b1011, S2, 1'b0);

        // Frame 9: alarm, phase 1 -> dark
        expect_at(146, "f9_alarm_off0", 4'b1111, S4, 1'b1);
        expect_at(154, "f9_alarm_off2", 4'b1111, S2, 1'b1);
        expect_at(158, "f9_alarm_off3", 4'b1111, S1, 1'b1);

        // Frame 10: alarm, phase 0 -> on
        expect_at(162, "f10_alarm_on",  4'b1110, S4, 1'b1);
        expect_at(170, "f10_alarm_dp",  4'b1011, S2, 1'b0);
        led = 1'b0;
        state = 3'd6;
        set_digits(4'd1, 4'd2, 4'hC, 4'hA);

        // Frame 11: illegal digits show dash; state 6 acts as IDLE in phase 1
        expect_at(178, "f11_illegal_s0", 4'b1110, DASH, 1'b1);
        expect_at(182, "f11_illegal_s1", 4'b1101, DASH, 1'b1);
        expect_at(186, "f11_st6_colon",  4'b1011, S2,   1'b0);

        // Mid-frame reset restarts at idx 0 with a zero snapshot
        expect_at(187, "pre_rst_idx2",   4'b1011, S2,   1'b0);
        reset_n = 1'b0;
        #1;
        check("midframe_reset", {an, seg, dp}, {4'b1111, SOFF, 1'b1});
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        expect_at(1,  "rst2_guard0",   4'b1111, S0, 1'b1);
        expect_at(2,  "rst2_idx0",     4'b1110, S0, 1'b1);
        expect_at(6,  "rst2_idx1",     4'b1101, S0, 1'b1);
        expect_at(14, "rst2_idx3_lz",  4'b1111, S0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
